// File: rtl/poli_array_ctrl.sv
// Polymorphic-logic cell array: per-channel mode registers, registered outputs with a
// post-reconfiguration settle window, and a built-in truth-table characterisation sweep.
module poli_array_ctrl #(
    parameter int CH     = 4,
    parameter int SETTLE = 3
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  cfg_wr,
    input  logic [$clog2(CH)-1:0] cfg_ch,
    input  logic [1:0]            cfg_mode,
    output logic                  cfg_err,
    input  logic [CH-1:0]         a,
    input  logic [CH-1:0]         b,
    output logic [CH-1:0]         x,
    output logic [CH-1:0]         x_valid,
    input  logic                  char_start,
    input  logic [$clog2(CH)-1:0] char_ch,
    output logic                  char_busy,
    output logic                  char_done,
    output logic [15:0]           char_tt
);

    localparam int CW   = $clog2(CH);
    localparam int SW   = $clog2(SETTLE + 1);
    localparam int CMAX = (SETTLE > 4) ? SETTLE : 4;
    localparam int CNTW = $clog2(CMAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_RESTORE,
        ST_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [1:0]        m_q, m_d;
    logic [CW-1:0]     ch_q, ch_d;
    logic [1:0]        saved_q, saved_d;
    logic [15:0]       tt_q, tt_d;
    logic              cap_pend_q, cap_pend_d;
    logic [3:0]        cap_idx_q, cap_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        mode_q [CH];
    logic [1:0]        mode_d [CH];
    logic [SW-1:0]     settle_q [CH];
    logic [SW-1:0]     settle_d [CH];
    logic [CH-1:0]     x_q, x_d;
    logic [CH-1:0]     x_valid_q, x_valid_d;

    logic              char_go;
    logic              cfg_ok;
    logic              mode_wr;
    logic [CW-1:0]     mode_wr_ch;
    logic [1:0]        mode_wr_val;
    logic [CH-1:0]     in_a, in_b;

    function automatic logic cell_f(input logic [1:0] m, input logic ai, input logic bi);
        case (m)
            2'b00:   return ~(ai | bi);
            2'b01:   return ~(ai & bi);
            2'b10:   return ai;
            default: return ai ^ bi;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        m_d         = m_q;
        ch_d        = ch_q;
        saved_d     = saved_q;
        tt_d        = tt_q;
        cap_pend_d  = 1'b0;
        cap_idx_d   = cap_idx_q;
        done_d      = 1'b0;
        mode_wr     = 1'b0;
        mode_wr_ch  = ch_q;
        mode_wr_val = 2'b00;
        in_a        = a;
        in_b        = b;

        // char_start has priority: a coincident cfg_wr is always rejected
        char_go = char_start && (state_q == ST_IDLE) && (int'(char_ch) < CH);
        cfg_ok  = cfg_wr && !char_start && (state_q == ST_IDLE) && (int'(cfg_ch) < CH);
        err_d   = cfg_wr && !cfg_ok;

        if (cap_pend_q) begin
            for (int c = 0; c < CH; c++) begin
                if (int'(ch_q) == c) tt_d[cap_idx_q] = x_q[c];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (char_go) begin
                    state_d     = ST_SETTLE;
                    cnt_d       = '0;
                    m_d         = 2'b00;
                    ch_d        = char_ch;
                    tt_d        = '0;
                    mode_wr     = 1'b1;
                    mode_wr_ch  = char_ch;
                    mode_wr_val = 2'b00;
                    for (int c = 0; c < CH; c++) begin
                        if (int'(char_ch) == c) saved_d = mode_q[c];
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNTW'(SETTLE - 1)) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_SWEEP: begin
                // x for combo i registers this edge and is captured on the next one
                cap_pend_d = 1'b1;
                cap_idx_d  = {m_q, cnt_q[1:0]};
                if (cnt_q == CNTW'(3)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_DRAIN: begin
                mode_wr = 1'b1;
                cnt_d   = '0;
                if (m_q == 2'b11) begin
                    state_d     = ST_RESTORE;
                    mode_wr_val = saved_q;
                end else begin
                    state_d     = ST_SETTLE;
                    m_d         = m_q + 2'd1;
                    mode_wr_val = m_q + 2'd1;
                end
            end
            ST_RESTORE: begin
                if (cnt_q == CNTW'(SETTLE - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);

        for (int c = 0; c < CH; c++) begin
            mode_d[c]   = mode_q[c];
            settle_d[c] = (settle_q[c] != '0) ? settle_q[c] - SW'(1) : settle_q[c];
            if (cfg_ok && (int'(cfg_ch) == c) && (cfg_mode != mode_q[c])) begin
                mode_d[c]   = cfg_mode;
                settle_d[c] = SW'(SETTLE);
            end
            if (mode_wr && (int'(mode_wr_ch) == c)) mode_d[c] = mode_wr_val;

            // the channel under characterisation sees the sweep pattern, never external inputs
            if ((state_q != ST_IDLE) && (int'(ch_q) == c)) begin
                in_a[c] = (state_q == ST_SWEEP) && cnt_q[0];
                in_b[c] = (state_q == ST_SWEEP) && cnt_q[1];
            end
            x_d[c]       = cell_f(mode_q[c], in_a[c], in_b[c]);
            x_valid_d[c] = (settle_d[c] == '0) && !(busy_d && (int'(ch_d) == c));
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            m_q        <= 2'b00;
            ch_q       <= '0;
            saved_q    <= 2'b00;
            tt_q       <= '0;
            cap_pend_q <= 1'b0;
            cap_idx_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            x_q        <= '0;
            x_valid_q  <= '1;
            for (int c = 0; c < CH; c++) begin
                mode_q[c]   <= 2'b01;
                settle_q[c] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            m_q        <= m_d;
            ch_q       <= ch_d;
            saved_q    <= saved_d;
            tt_q       <= tt_d;
            cap_pend_q <= cap_pend_d;
            cap_idx_q  <= cap_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            x_q        <= x_d;
            x_valid_q  <= x_valid_d;
            for (int c = 0; c < CH; c++) begin
                mode_q[c]   <= mode_d[c];
                settle_q[c] <= settle_d[c];
            end
        end
    end

    assign cfg_err   = err_q;
    assign x         = x_q;
    assign x_valid   = x_valid_q;
    assign char_busy = busy_q;
    assign char_done = done_q;
    assign char_tt   = tt_q;

endmodule

// File: tb/tb_poli_array_ctrl.sv
// Directed bench for poli_array_ctrl: cell-output scoreboard plus assertion checks on
// settle windows, config rejection, characterisation timing/result and mid-sweep reset.
module tb_poli_array_ctrl;

    localparam int CH     = 4;
    localparam int SETTLE = 3;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          cfg_wr, char_start, cfg_err, char_busy, char_done;
    logic [1:0]    cfg_ch, char_ch, cfg_mode;
    logic [CH-1:0] a, b, x, x_valid;
    logic [15:0]   char_tt;

    // three-channel instance: the only way to present an out-of-range channel number
    logic          cfg_wr3, char_start3, cfg_err3, char_busy3, char_done3;
    logic [1:0]    cfg_ch3, char_ch3, cfg_mode3;
    logic [2:0]    a3, b3, x3, x_valid3;
    logic [15:0]   char_tt3;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string         tag;
        logic [CH-1:0] mask;
        logic [CH-1:0] exp_x;
    } exp_t;

    exp_t          sb_q[$];
    logic [1:0]    mdl_mode [CH];
    logic [CH-1:0] ra, rb;

    always #5 clk = ~clk;

    poli_array_ctrl #(.CH(CH), .SETTLE(SETTLE)) u_dut (
        .clk(clk), .n_rst(n_rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_err(cfg_err), .a(a), .b(b), .x(x), .x_valid(x_valid),
        .char_start(char_start), .char_ch(char_ch), .char_busy(char_busy),
        .char_done(char_done), .char_tt(char_tt)
    );

    poli_array_ctrl #(.CH(3), .SETTLE(SETTLE)) u_dut3 (
        .clk(clk), .n_rst(n_rst), .cfg_wr(cfg_wr3), .cfg_ch(cfg_ch3), .cfg_mode(cfg_mode3),
        .cfg_err(cfg_err3), .a(a3), .b(b3), .x(x3), .x_valid(x_valid3),
        .char_start(char_start3), .char_ch(char_ch3), .char_busy(char_busy3),
        .char_done(char_done3), .char_tt(char_tt3)
    );

    function automatic logic ref_cell(input logic [1:0] m, input logic av, input logic bv);
        case (m)
            2'b00:   return !(av || bv);
            2'b01:   return !(av && bv);
            2'b10:   return av;
            default: return av != bv;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a/b for one edge, predicts x for the unmasked channels, then compares.
    task automatic applyStimulus(input string tag, input logic [CH-1:0] av,
                                 input logic [CH-1:0] bv, input logic [CH-1:0] mask);
        exp_t e;
        a = av;
        b = bv;
        e.tag  = tag;
        e.mask = mask;
        for (int c = 0; c < CH; c++) e.exp_x[c] = ref_cell(mdl_mode[c], av[c], bv[c]);
        sb_q.push_back(e);
        tick();
        cfg_wr      = 1'b0;
        char_start  = 1'b0;
        cfg_wr3     = 1'b0;
        char_start3 = 1'b0;
        e = sb_q.pop_front();
        checkOutput(e.tag, 32'(x & e.mask), 32'(e.exp_x & e.mask));
    endtask

    task automatic resetModel();
        for (int c = 0; c < CH; c++) mdl_mode[c] = 2'b01;
    endtask

    initial begin
        n_rst = 1'b1;
        cfg_wr = 1'b0; cfg_ch = '0; cfg_mode = '0; char_start = 1'b0; char_ch = '0;
        a = '1; b = '1;
        cfg_wr3 = 1'b0; cfg_ch3 = '0; cfg_mode3 = '0; char_start3 = 1'b0; char_ch3 = '0;
        a3 = '1; b3 = '1;
        resetModel();

        #1 n_rst = 1'b0;
        #2;
        checkOutput("rst_x", 32'(x), 32'h0);
        checkOutput("rst_x_valid", 32'(x_valid), 32'hF);
        checkOutput("rst_tt", 32'(char_tt), 32'h0);
        checkOutput("rst_busy", 32'(char_busy), 32'h0);
        checkOutput("rst_done", 32'(char_done), 32'h0);
        checkOutput("rst_err", 32'(cfg_err), 32'h0);
        tick();
        tick();
        n_rst = 1'b1;

        applyStimulus("nand_all_ones", 4'hF, 4'hF, 4'hF);
        checkOutput("valid_after_reset", 32'(x_valid), 32'hF);
        checkOutput("tt_after_reset", 32'(char_tt), 32'h0);

        // ch1 -> XOR with a[1]=1, b[1]=0
        cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_mode = 2'b11;
        applyStimulus("cfg_edge_x", 4'hF, 4'b1101, 4'b1101);
        mdl_mode[1] = 2'b11;
        checkOutput("cfg_accept_err", 32'(cfg_err), 32'h0);
        checkOutput("x1_after_cfg", 32'(x[1]), 32'h1);
        checkOutput("settle_valid_0", 32'(x_valid), 32'hD);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus("xor_window_x", 4'hF, 4'b1101, 4'hF);
            checkOutput($sformatf("settle_valid_%0d", k), 32'(x_valid), (k < 3) ? 32'hD : 32'hF);
        end
        for (int k = 0; k < 6; k++) begin
            ra = CH'($urandom);
            rb = CH'($urandom);
            applyStimulus("random_x", ra, rb, 4'hF);
        end

        // rewriting the current mode is a no-op
        cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_mode = 2'b11;
        for (int k = 0; k < 3; k++) begin
            applyStimulus("same_mode_x", CH'($urandom), CH'($urandom), 4'hF);
            checkOutput("same_mode_valid", 32'(x_valid), 32'hF);
        end
        checkOutput("same_mode_err", 32'(cfg_err), 32'h0);

        // second write inside the window restarts the settle count
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'b00;
        applyStimulus("restart_w1_x", CH'($urandom), CH'($urandom), 4'b1110);
        mdl_mode[0] = 2'b00;
        checkOutput("restart_w1_valid", 32'(x_valid), 32'hE);
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'b10;
        applyStimulus("restart_w2_x", CH'($urandom), CH'($urandom), 4'b1110);
        mdl_mode[0] = 2'b10;
        checkOutput("restart_w2_valid", 32'(x_valid), 32'hE);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus("restart_x", CH'($urandom), CH'($urandom), 4'hF);
            checkOutput($sformatf("restart_valid_%0d", k), 32'(x_valid), (k < 3) ? 32'hE : 32'hF);
        end

        cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_mode = 2'b00;
        applyStimulus("ch2_nor_x", CH'($urandom), CH'($urandom), 4'b1011);
        mdl_mode[2] = 2'b00;
        for (int k = 0; k < 3; k++) applyStimulus("ch2_settle_x", CH'($urandom), CH'($urandom), 4'hF);
        checkOutput("ch2_settled_valid", 32'(x_valid), 32'hF);

        // out-of-range channel on the 3-channel instance; BUF(1) would expose a stray write
        cfg_wr3 = 1'b1; cfg_ch3 = 2'd3; cfg_mode3 = 2'b10;
        applyStimulus("oor_x", CH'($urandom), CH'($urandom), 4'hF);
        checkOutput("oor_cfg_err", 32'(cfg_err3), 32'h1);
        checkOutput("oor_valid", 32'(x_valid3), 32'h7);
        char_start3 = 1'b1; char_ch3 = 2'd3;
        applyStimulus("oor_char_x", CH'($urandom), CH'($urandom), 4'hF);
        checkOutput("oor_err_pulse_end", 32'(cfg_err3), 32'h0);
        checkOutput("oor_char_ignored", 32'(char_busy3), 32'h0);
        applyStimulus("oor_idle_x", CH'($urandom), CH'($urandom), 4'hF);
        checkOutput("oor_modes_kept", 32'(x3), 32'h0);
        checkOutput("oor_char_still_idle", 32'(char_busy3), 32'h0);

        // characterise ch2 (NOR) with a coincident cfg_wr that must be rejected
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'b11;
        char_start = 1'b1; char_ch = 2'd2;
        applyStimulus("char_start_x", CH'($urandom), CH'($urandom), 4'b1011);
        checkOutput("char_vs_cfg_err", 32'(cfg_err), 32'h1);
        checkOutput("char_busy_start", 32'(char_busy), 32'h1);
        checkOutput("char_tt_cleared", 32'(char_tt), 32'h0);
        checkOutput("char_valid_start", 32'(x_valid), 32'hB);
        for (int k = 1; k <= 36; k++) begin
            if (k == 5) begin
                cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_mode = 2'b00;
            end
            if (k == 8) begin
                char_start = 1'b1; char_ch = 2'd1;
            end
            applyStimulus("char_other_x", CH'($urandom), CH'($urandom), 4'b1011);
            if (k == 5) checkOutput("busy_cfg_err", 32'(cfg_err), 32'h1);
            if (k == 12 || k == 35 || k == 36) begin
                checkOutput($sformatf("char_busy_%0d", k), 32'(char_busy), (k < 36) ? 32'h1 : 32'h0);
                checkOutput($sformatf("char_valid_%0d", k), 32'(x_valid), (k < 36) ? 32'hB : 32'hF);
            end
            if (char_done !== (k == 36)) checkOutput($sformatf("char_done_%0d", k), 32'(char_done), 32'(k == 36));
        end
        checkOutput("char_done_at_36", 32'(char_done), 32'h1);
        checkOutput("char_tt_ch2", 32'(char_tt), 32'h6A71);
        applyStimulus("ch2_restored_x", 4'h0, 4'h0, 4'hF);
        checkOutput("char_done_pulse", 32'(char_done), 32'h0);
        checkOutput("char_tt_hold", 32'(char_tt), 32'h6A71);

        // asynchronous reset at sweep cycle 10
        char_start = 1'b1; char_ch = 2'd3;
        applyStimulus("abort_start_x", CH'($urandom), CH'($urandom), 4'b0111);
        for (int k = 1; k <= 10; k++) applyStimulus("abort_run_x", CH'($urandom), CH'($urandom), 4'b0111);
        #3 n_rst = 1'b0;
        #1;
        checkOutput("abort_x", 32'(x), 32'h0);
        checkOutput("abort_valid", 32'(x_valid), 32'hF);
        checkOutput("abort_busy", 32'(char_busy), 32'h0);
        checkOutput("abort_tt", 32'(char_tt), 32'h0);
        checkOutput("abort_err", 32'(cfg_err), 32'h0);
        tick();
        n_rst = 1'b1;
        resetModel();

        char_start = 1'b1; char_ch = 2'd3;
        applyStimulus("fresh_start_x", CH'($urandom), CH'($urandom), 4'b0111);
        checkOutput("fresh_busy", 32'(char_busy), 32'h1);
        for (int k = 1; k <= 36; k++) begin
            applyStimulus("fresh_other_x", CH'($urandom), CH'($urandom), 4'b0111);
            if (char_done !== (k == 36)) checkOutput($sformatf("fresh_done_%0d", k), 32'(char_done), 32'(k == 36));
        end
        checkOutput("fresh_done_at_36", 32'(char_done), 32'h1);
        checkOutput("fresh_tt", 32'(char_tt), 32'h6A71);
        applyStimulus("ch3_restored_x", 4'hF, 4'h7, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
